// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with blanking gap and per-frame shadow latch.
// Define LEADING_ZERO_BLANK_EN to darken zero digits above the highest non-zero digit.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_multiplex,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {WAIT, BLANK, SHOW} state_t;
  state_t state, state_n;
  logic s0, s1, s2, tick, load;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blank, eff_blank, an_n;
  logic [6:0] seg_n;
  logic dp_n;
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction
  assign tick = s1 & ~s2;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  // lz[i] set while every digit from i upward is zero; digit 0 is always kept
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = digits_in[4*NUM_DIGITS-1 -: 4] == 4'h0;
    for (int i = NUM_DIGITS - 2; i >= 1; i--) lz[i] = lz[i+1] & (digits_in[4*i +: 4] == 4'h0);
    eff_blank = blank_in | lz;
  end
`else
  assign eff_blank = blank_in;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    load    = 1'b0;
    case (state)
      WAIT: if (tick) begin
        idx_n   = '0;
        load    = 1'b1;
        cnt_n   = CW'(BLANK_CYCLES - 1);
        state_n = BLANK;
      end
      SHOW: if (tick) begin
        idx_n   = idx == LAST ? '0 : idx + 1'b1;
        load    = idx == LAST;
        cnt_n   = CW'(BLANK_CYCLES - 1);
        state_n = BLANK;
      end
      BLANK: if (cnt != '0) cnt_n = cnt - 1'b1; else state_n = SHOW;
      default: state_n = WAIT;
    endcase
    an_n  = '1;
    seg_n = 7'h7F;
    dp_n  = 1'b1;
    // idx and shadows never change on an edge that lands in SHOW, so current values are the next ones
    if (state_n == SHOW && !sh_blank[idx]) begin
      an_n[idx] = 1'b0;
      seg_n     = decode(sh_dig[4*idx +: 4]);
      dp_n      = ~sh_dp[idx];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s0, s1, s2} <= '0;
      state        <= WAIT;
      cnt          <= '0;
      idx          <= '0;
      sh_dig       <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      s0          <= clk_multiplex;
      s1          <= s0;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      if (load) begin
        sh_dig   <= digits_in;
        sh_dp    <= dp_in;
        sh_blank <= eff_blank;
      end
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      frame_start <= load;
    end
endmodule
